// File: rtl/clk_sample_sched.sv
// clk_sample_sched
//   Sequencing controller for the phase-accumulator sample-clock generator.
//   Owns the phase accumulator, the active tuning word, a one-deep pending
//   tuning-word register and a run/burst state machine (IDLE, RUN, STOP_PEND).
//
// Configuration macro: CLK_SAMPLE_WRAP_UPDATE_EN
//   defined   : a pending tuning word is applied in RUN/STOP_PEND only on the
//               edge that wraps the accumulator (phase-continuous boundaries).
//   undefined : a pending tuning word is applied on the edge after its transfer
//               in every state.
//
// Ports
//   clk_in      system clock
//   RST         asynchronous active-high reset
//   cfg_fre     tuning word, output rate = f_clk*cfg_fre/2^PHASE_WIDTH
//   cfg_valid   cfg_fre valid
//   cfg_ready   pending register free, cfg_fre can be accepted
//   start       begin a run (IDLE only)
//   stop        stop at the next period boundary
//   burst_len   samples per run, latched at start, 0 = continuous
//   busy        state is not IDLE
//   done        one-cycle pulse when a run ends
//   clk_sample  accumulator MSB (square sample clock)
//   sample_stb  one-cycle pulse per accumulator wrap
//   sample_cnt  samples produced in the current run
module clk_sample_sched #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic [PHASE_WIDTH-1:0] cfg_fre,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CNT_WIDTH-1:0]   burst_len,
    output logic                   busy,
    output logic                   done,
    output logic                   clk_sample,
    output logic                   sample_stb,
    output logic [CNT_WIDTH-1:0]   sample_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] acc_nxt;
    logic [PHASE_WIDTH-1:0] active_fre;
    logic [PHASE_WIDTH-1:0] active_nxt;
    logic [PHASE_WIDTH-1:0] pend_fre;
    logic [PHASE_WIDTH-1:0] pend_nxt;
    logic                   pend_valid;
    logic                   pend_valid_nxt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [CNT_WIDTH-1:0]   burst_reg;
    logic [CNT_WIDTH-1:0]   burst_nxt;
    logic                   stb_nxt;
    logic                   done_nxt;
    logic [PHASE_WIDTH:0]   sum;
    logic                   wrap;
    logic                   burst_end;
    logic                   apply;

    // One extra bit on the adder gives the carry-out that marks a period boundary.
    assign sum       = {1'b0, acc} + {1'b0, active_fre};
    assign wrap      = sum[PHASE_WIDTH];
    assign cnt_inc   = sample_cnt + CNT_WIDTH'(1);
    assign burst_end = (burst_reg != '0) && (cnt_inc == burst_reg);

`ifdef CLK_SAMPLE_WRAP_UPDATE_EN
    // A zero tuning word never wraps, so it would otherwise lock out every
    // later update; with no running phase there is no boundary to protect.
    assign apply = pend_valid && ((state == IDLE) || wrap || (active_fre == '0));
`else
    assign apply = pend_valid;
`endif

    assign cfg_ready  = !pend_valid;
    assign busy       = (state != IDLE);
    assign clk_sample = acc[PHASE_WIDTH-1];

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = sample_cnt;
        burst_nxt      = burst_reg;
        stb_nxt        = 1'b0;
        done_nxt       = 1'b0;
        active_nxt     = active_fre;
        pend_nxt       = pend_fre;
        pend_valid_nxt = pend_valid;

        // Apply and transfer are mutually exclusive: a transfer needs an empty
        // pending register, an apply needs a full one.
        if (apply) begin
            active_nxt     = pend_fre;
            pend_valid_nxt = 1'b0;
        end
        if (cfg_valid && cfg_ready) begin
            pend_nxt       = cfg_fre;
            pend_valid_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                acc_nxt = '0;
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    burst_nxt = burst_len;
                end
            end
            RUN: begin
                acc_nxt = sum[PHASE_WIDTH-1:0];
                if (wrap) begin
                    stb_nxt = 1'b1;
                    cnt_nxt = cnt_inc;
                end
                if (wrap && burst_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    acc_nxt   = '0;
                end else if (stop) begin
                    if (active_fre == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        acc_nxt   = '0;
                    end else begin
                        state_nxt = STOP_PEND;
                    end
                end
            end
            STOP_PEND: begin
                acc_nxt = sum[PHASE_WIDTH-1:0];
                if (wrap) begin
                    // Covers a coincident burst end too: one strobe, one done.
                    stb_nxt   = 1'b1;
                    cnt_nxt   = cnt_inc;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    acc_nxt   = '0;
                end else if (active_fre == '0) begin
                    // Tuning word dropped to zero while waiting: no wrap will come.
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    acc_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            acc        <= '0;
            active_fre <= '0;
            pend_fre   <= '0;
            pend_valid <= 1'b0;
            sample_cnt <= '0;
            burst_reg  <= '0;
            sample_stb <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            active_fre <= active_nxt;
            pend_fre   <= pend_nxt;
            pend_valid <= pend_valid_nxt;
            sample_cnt <= cnt_nxt;
            burst_reg  <= burst_nxt;
            sample_stb <= stb_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_clk_sample_sched.sv
module tb_clk_sample_sched;

    localparam int unsigned PW = 32;
    localparam int unsigned CW = 16;

    logic          clk_in = 1'b0;
    logic          RST;
    logic [PW-1:0] cfg_fre;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          start;
    logic          stop;
    logic [CW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          clk_sample;
    logic          sample_stb;
    logic [CW-1:0] sample_cnt;

    clk_sample_sched #(
        .PHASE_WIDTH(PW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .cfg_fre   (cfg_fre),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .start     (start),
        .stop      (stop),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .clk_sample(clk_sample),
        .sample_stb(sample_stb),
        .sample_cnt(sample_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Number of rising edges seen so far; event times are expressed in it.
    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        logic          stb;
        logic          dn;
        logic [CW-1:0] cnt;
        logic          clk_s;
    } ev_t;

    ev_t sbq[$];
    ev_t mon_e;
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int unsigned c, input logic s, input logic d,
                           input int unsigned n, input logic k);
        ev_t e;
        e.cyc   = c;
        e.stb   = s;
        e.dn    = d;
        e.cnt   = n[CW-1:0];
        e.clk_s = k;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Monitor: every strobe or done the DUT shows is matched against the queue.
    always @(negedge clk_in) begin
        if (sample_stb || done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: cyc=%0d stb=%b done=%b cnt=%0d",
                         cyc, sample_stb, done, sample_cnt);
            end else begin
                mon_e = sbq.pop_front();
                check("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("ev_stb", 64'(sample_stb), 64'(mon_e.stb));
                check("ev_done", 64'(done), 64'(mon_e.dn));
                check("ev_cnt", 64'(sample_cnt), 64'(mon_e.cnt));
                check("ev_clk_sample", 64'(clk_sample), 64'(mon_e.clk_s));
            end
        end
    end

    int unsigned n;

    initial begin
        RST       = 1'b1;
        cfg_fre   = '0;
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        burst_len = '0;
        repeat (2) tick();

        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stb", 64'(sample_stb), 64'd0);
        check("rst_clk_sample", 64'(clk_sample), 64'd0);
        check("rst_cnt", 64'(sample_cnt), 64'd0);
        RST = 1'b0;
        tick();

        // Burst of 3 at period 4.
        cfg_fre   = 32'h4000_0000;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("t1_ready_low", 64'(cfg_ready), 64'd0);
        tick();
        check("t1_ready_high", 64'(cfg_ready), 64'd1);
        start     = 1'b1;
        burst_len = 16'd3;
        n         = cyc;
        push_ev(n + 5, 1'b1, 1'b0, 1, 1'b0);
        push_ev(n + 9, 1'b1, 1'b0, 2, 1'b0);
        push_ev(n + 13, 1'b1, 1'b1, 3, 1'b0);
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("t1_clk_sample", 64'(clk_sample), 64'((k % 4) >= 2));
            check("t1_busy", 64'(busy), 64'd1);
            tick();
        end
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_cnt_final", 64'(sample_cnt), 64'd3);
        tick();
        check("t1_cnt_hold", 64'(sample_cnt), 64'd3);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // Stop one cycle after a strobe, period 4.
        start     = 1'b1;
        burst_len = 16'd0;
        n         = cyc;
        push_ev(n + 5, 1'b1, 1'b0, 1, 1'b0);
        push_ev(n + 9, 1'b1, 1'b1, 2, 1'b0);
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_busy_stop_pend", 64'(busy), 64'd1);
        check("t4_clk_low", 64'(clk_sample), 64'd0);
        repeat (2) tick();
        check("t4_clk_high", 64'(clk_sample), 64'd1);
        tick();
        check("t4_busy_idle", 64'(busy), 64'd0);
        check("t4_acc_zero", 64'(dut.acc), 64'd0);
        tick();
        check("t4_acc_zero_hold", 64'(dut.acc), 64'd0);

        // Continuous run, tuning word change mid-period, start in RUN ignored.
        start = 1'b1;
        n     = cyc;
        push_ev(n + 5, 1'b1, 1'b0, 1, 1'b0);
        push_ev(n + 9, 1'b1, 1'b0, 2, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        cfg_fre   = 32'h8000_0000;
        cfg_valid = 1'b1;
        push_ev(n + 13, 1'b1, 1'b0, 3, 1'b0);
        push_ev(n + 15, 1'b1, 1'b0, 4, 1'b0);
        push_ev(n + 17, 1'b1, 1'b0, 5, 1'b0);
        tick();
        cfg_valid = 1'b0;
        check("t2_ready_after_xfer", 64'(cfg_ready), 64'd0);
        tick();
`ifdef CLK_SAMPLE_WRAP_UPDATE_EN
        check("t2_ready_wait_wrap", 64'(cfg_ready), 64'd0);
`else
        check("t2_ready_one_cycle", 64'(cfg_ready), 64'd1);
`endif
        tick();
        check("t2_ready_back", 64'(cfg_ready), 64'd1);
        tick();
        check("t2_clk_high", 64'(clk_sample), 64'd1);
        repeat (3) tick();
        stop = 1'b1;
        push_ev(n + 19, 1'b1, 1'b1, 6, 1'b0);
        tick();
        stop = 1'b0;
        tick();
        check("t2_busy_end", 64'(busy), 64'd0);

        // Zero tuning word: stop ends the run on the next edge, no strobe.
        cfg_fre   = '0;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t5_busy_run", 64'(busy), 64'd1);
        check("t5_clk_frozen", 64'(clk_sample), 64'd0);
        check("t5_cnt_zero", 64'(sample_cnt), 64'd0);
        stop = 1'b1;
        push_ev(cyc + 1, 1'b0, 1'b1, 0, 1'b0);
        tick();
        stop = 1'b0;
        check("t5_busy_idle", 64'(busy), 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("t5_stop_in_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-period with an update pending.
        cfg_fre   = 32'h4000_0000;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        start = 1'b1;
        n     = cyc;
        push_ev(n + 5, 1'b1, 1'b0, 1, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        cfg_fre   = 32'h2000_0000;
        cfg_valid = 1'b1;
        @(posedge clk_in);
        #2;
        cfg_valid = 1'b0;
        check("t6_pending", 64'(cfg_ready), 64'd0);
        check("t6_clk_pre", 64'(clk_sample), 64'd1);
        check("t6_busy_pre", 64'(busy), 64'd1);
        RST = 1'b1;
        #1;
        check("t6_rst_ready", 64'(cfg_ready), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_clk", 64'(clk_sample), 64'd0);
        check("t6_rst_cnt", 64'(sample_cnt), 64'd0);
        check("t6_rst_stb", 64'(sample_stb), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        repeat (2) tick();
        RST = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t6_no_fre_busy", 64'(busy), 64'd1);
        check("t6_no_fre_cnt", 64'(sample_cnt), 64'd0);
        stop = 1'b1;
        push_ev(cyc + 1, 1'b0, 1'b1, 0, 1'b0);
        tick();
        stop = 1'b0;
        cfg_fre   = 32'h4000_0000;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        start     = 1'b1;
        burst_len = 16'd2;
        n         = cyc;
        push_ev(n + 5, 1'b1, 1'b0, 1, 1'b0);
        push_ev(n + 9, 1'b1, 1'b1, 2, 1'b0);
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("t6_busy_end", 64'(busy), 64'd0);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout: cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
